// File: rtl/flash_sample_reader_if.sv
// Bus bundle for flash_sample_reader: Avalon-MM read master toward the flash core
// plus the valid/ready sample stream toward the downstream writer stage.
interface flash_sample_reader_if;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid,
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid,
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/flash_sample_reader.sv
// Sequential flash word fetcher that splits each 32-bit word into two 16-bit samples
// (low half first) and streams them through a FWFT FIFO. Optional macro: AUTO_LOOP_EN.
module flash_sample_reader #(
  parameter logic [22:0] START_WORD = 23'h000000,
  parameter logic [22:0] END_WORD   = 23'h0FFFFF,
  parameter int          DEPTH      = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     rst_n,
  input  logic                     enable,
  flash_sample_reader_if.master    bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, PUSH_HI} state_t;

  state_t        state_reg;
  logic          read_reg;
  logic [22:0]   addr_reg;
  logic [22:0]   ptr_reg;
  logic [15:0]   hi_reg;
  logic          done_reg;

  logic [15:0]   mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic [LW-1:0] free_space;
  logic          push;
  logic          pop;
  logic [15:0]   push_data;

  always_comb begin
    push       = ((state_reg == WAIT_DATA) && bus.flash_mem_readdatavalid) ||
                 (state_reg == PUSH_HI);
    push_data  = (state_reg == PUSH_HI) ? hi_reg : bus.flash_mem_readdata[15:0];
    pop        = (level_reg != '0) && bus.sample_ready;
    level_next = level_reg + LW'(push) - LW'(pop);
    free_space = LW'(DEPTH) - level_reg;
  end

  // Two free slots are required before a fetch so both halves always fit.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      read_reg  <= 1'b0;
      addr_reg  <= START_WORD;
      ptr_reg   <= START_WORD;
      hi_reg    <= 16'h0000;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable && !done_reg && (free_space >= LW'(2))) begin
            state_reg <= REQ;
            read_reg  <= 1'b1;
            addr_reg  <= ptr_reg;
          end
        end
        REQ: begin
          if (!bus.flash_mem_waitrequest) begin
            read_reg  <= 1'b0;
            state_reg <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (bus.flash_mem_readdatavalid) begin
            hi_reg    <= bus.flash_mem_readdata[31:16];
            state_reg <= PUSH_HI;
          end
        end
        PUSH_HI: begin
          state_reg <= IDLE;
          if (ptr_reg == END_WORD) begin
`ifdef AUTO_LOOP_EN
            ptr_reg <= START_WORD;
`else
            done_reg <= 1'b1;
`endif
          end else begin
            ptr_reg <= ptr_reg + 23'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign bus.flash_mem_read    = read_reg;
  assign bus.flash_mem_address = addr_reg;
  assign bus.sample_valid      = (level_reg != '0);
  assign bus.sample_data       = (level_reg != '0) ? mem_reg[rd_ptr_reg] : 16'h0000;
  assign fifo_level            = level_reg;
  assign done                  = done_reg;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader: one default-parameter instance plus a
// small-image instance (END_WORD=3) for the end-of-image / wrap behaviour.
module tb_flash_sample_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic en     = 1'b0;
  logic rdy    = 1'b0;
  logic en_w   = 1'b0;
  logic rdy_w  = 1'b0;
  logic [22:0] stall_addr   = 23'h7FFFFF;
  int          stall_cycles = 0;

  int total  = 0;
  int passed = 0;

  flash_sample_reader_if bus();
  flash_sample_reader_if bus_w();
  logic [3:0] level, level_w;
  logic       done, done_w;

  flash_sample_reader dut (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .enable     (en),
    .bus        (bus),
    .fifo_level (level),
    .done       (done)
  );

  flash_sample_reader #(.START_WORD(23'h0), .END_WORD(23'h3), .DEPTH(8)) dut_w (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .enable     (en_w),
    .bus        (bus_w),
    .fifo_level (level_w),
    .done       (done_w)
  );

  function automatic logic [31:0] fdata(input logic [22:0] a);
    if (a == 23'd0) return 32'hFFFE_0003;
    return {16'hC000 | a[15:0], 16'h2000 | a[15:0]};
  endfunction

  // Flash model for the main instance: optional stall on one address, data two edges after acceptance.
  int          stall_seen;
  logic        pend, rdv;
  logic [22:0] pend_addr;
  logic [31:0] rdata;
  assign bus.flash_mem_waitrequest   = bus.flash_mem_read && (bus.flash_mem_address == stall_addr) &&
                                       (stall_seen < stall_cycles);
  assign bus.flash_mem_readdatavalid = rdv;
  assign bus.flash_mem_readdata      = rdata;
  assign bus.sample_ready            = rdy;

  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0; rdv <= 1'b0; rdata <= 32'h0; stall_seen <= 0; pend_addr <= 23'h0;
    end else begin
      rdv <= 1'b0;
      if (bus.flash_mem_waitrequest) stall_seen <= stall_seen + 1;
      else if (bus.flash_mem_read) begin
        stall_seen <= 0; pend <= 1'b1; pend_addr <= bus.flash_mem_address;
      end
      if (pend) begin rdv <= 1'b1; rdata <= fdata(pend_addr); pend <= 1'b0; end
    end
  end

  // Flash model for the small-image instance: never stalls.
  logic        pend_w, rdv_w;
  logic [22:0] pend_addr_w;
  logic [31:0] rdata_w;
  assign bus_w.flash_mem_waitrequest   = 1'b0;
  assign bus_w.flash_mem_readdatavalid = rdv_w;
  assign bus_w.flash_mem_readdata      = rdata_w;
  assign bus_w.sample_ready            = rdy_w;

  always @(posedge clk) begin
    if (!rst_n) begin
      pend_w <= 1'b0; rdv_w <= 1'b0; rdata_w <= 32'h0; pend_addr_w <= 23'h0;
    end else begin
      rdv_w <= 1'b0;
      if (bus_w.flash_mem_read) begin pend_w <= 1'b1; pend_addr_w <= bus_w.flash_mem_address; end
      if (pend_w) begin rdv_w <= 1'b1; rdata_w <= fdata(pend_addr_w); pend_w <= 1'b0; end
    end
  end

  // Monitors record accepted addresses and popped samples (pre-edge values).
  int          cyc = 0;
  logic [22:0] addrs[$];
  logic [15:0] got[$];
  int          gcyc[$];
  logic [22:0] addrs_w[$];
  logic [15:0] got_w[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      addrs.delete(); got.delete(); gcyc.delete(); addrs_w.delete(); got_w.delete();
    end else begin
      if (bus.flash_mem_read && !bus.flash_mem_waitrequest) addrs.push_back(bus.flash_mem_address);
      if (bus.sample_valid && bus.sample_ready) begin got.push_back(bus.sample_data); gcyc.push_back(cyc); end
      if (bus_w.flash_mem_read && !bus_w.flash_mem_waitrequest) addrs_w.push_back(bus_w.flash_mem_address);
      if (bus_w.sample_valid && bus_w.sample_ready) got_w.push_back(bus_w.sample_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [22:0] exp_wrap [6];

  initial begin
    exp_wrap = '{23'd0, 23'd1, 23'd2, 23'd3, 23'd0, 23'd1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_read",  bus.flash_mem_read, 0);
    check("rst_addr",  bus.flash_mem_address, 0);
    check("rst_valid", bus.sample_valid, 0);
    check("rst_level", level, 0);
    check("rst_done",  done, 0);
    check("rst_data",  bus.sample_data, 0);
    rst_n = 1'b1;

    // 1: zero-wait fetch of word 0, sample_ready held high
    rdy = 1'b1; en = 1'b1;
    for (int i = 0; i < 200 && !(got.size() >= 2 && addrs.size() >= 2); i++) @(negedge clk);
    $display("t1: samples=%0d addrs=%0d", got.size(), addrs.size());
    check("t1_progress", (got.size() >= 2 && addrs.size() >= 2), 1);
    check("t1_lo",       got[0], 16'h0003);
    check("t1_hi",       got[1], 16'hFFFE);
    check("t1_consec",   gcyc[1] - gcyc[0], 1);
    check("t1_addr0",    addrs[0], 0);
    check("t1_addr1",    addrs[1], 1);

    // 2: five-cycle stall on word 4
    en = 1'b0; do_reset();
    stall_addr = 23'd4; stall_cycles = 5; rdy = 1'b1; en = 1'b1;
    for (int i = 0; i < 300 && !(bus.flash_mem_read && bus.flash_mem_address == 23'd4); i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("t2_stall", {bus.flash_mem_read, bus.flash_mem_waitrequest, bus.flash_mem_address}, {2'b11, 23'd4});
      @(negedge clk);
    end
    check("t2_accept", {bus.flash_mem_read, bus.flash_mem_waitrequest, bus.flash_mem_address}, {2'b10, 23'd4});
    @(negedge clk);
    check("t2_drop", bus.flash_mem_read, 0);
    for (int i = 0; i < 200 && got.size() < 11; i++) @(negedge clk);
    $display("t2: samples=%0d", got.size());
    check("t2_lo4", got[8],  16'h2004);
    check("t2_hi4", got[9],  16'hC004);
    check("t2_lo5", got[10], 16'h2005);

    // 3: backpressure fills the FIFO, two pops free room for one more word
    en = 1'b0; stall_addr = 23'h7FFFFF; rdy = 1'b0; do_reset(); en = 1'b1;
    for (int i = 0; i < 300 && level != 4'd8; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    $display("t3: level=%0d reads=%0d", level, addrs.size());
    check("t3_full",   level, 8);
    check("t3_reads",  addrs.size(), 4);
    check("t3_noread", bus.flash_mem_read, 0);
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    check("t3_level6", level, 6);
    check("t3_pop0",   got[0], 16'h0003);
    check("t3_pop1",   got[1], 16'hFFFE);
    for (int i = 0; i < 100 && addrs.size() < 5; i++) @(negedge clk);
    check("t3_addr4",  addrs[4], 4);

    // 5: enable dropped during WAIT_DATA of word 2
    en = 1'b0; rdy = 1'b1; do_reset(); en = 1'b1;
    for (int i = 0; i < 300 && !(bus.flash_mem_read && bus.flash_mem_address == 23'd2); i++) @(negedge clk);
    for (int i = 0; i < 50 && bus.flash_mem_read; i++) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    $display("t5: reads=%0d samples=%0d", addrs.size(), got.size());
    check("t5_reads",   addrs.size(), 3);
    check("t5_samples", got.size(), 6);
    check("t5_lo2",     got[4], 16'h2002);
    check("t5_hi2",     got[5], 16'hC002);
    check("t5_parked",  bus.flash_mem_read, 0);
    en = 1'b1;
    for (int i = 0; i < 100 && addrs.size() < 4; i++) @(negedge clk);
    check("t5_resume",  addrs[3], 3);

    // 6: async reset while stalled in REQ
    en = 1'b0; rdy = 1'b0; do_reset();
    stall_addr = 23'd2; stall_cycles = 1000; en = 1'b1;
    for (int i = 0; i < 300 && !(bus.flash_mem_read && bus.flash_mem_address == 23'd2); i++) @(negedge clk);
    check("t6_pre_level", level, 4);
    #2 rst_n = 1'b0;
    #1;
    $display("t6: in reset read=%0d level=%0d valid=%0d", bus.flash_mem_read, level, bus.sample_valid);
    check("t6_read",  bus.flash_mem_read, 0);
    check("t6_level", level, 0);
    check("t6_valid", bus.sample_valid, 0);
    check("t6_addr",  bus.flash_mem_address, 0);
    stall_addr = 23'h7FFFFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100 && addrs.size() < 1; i++) @(negedge clk);
    check("t6_restart", addrs[0], 0);

    // 4: end of image on the small-image instance
    en = 1'b0; do_reset();
`ifndef AUTO_LOOP_EN
    rdy_w = 1'b0; en_w = 1'b1;
    for (int i = 0; i < 300 && !done_w; i++) @(negedge clk);
    check("t4_done",       done_w, 1);
    check("t4_done_level", level_w, 8);
    repeat (10) @(negedge clk);
    $display("t4: reads=%0d level=%0d", addrs_w.size(), level_w);
    check("t4_reads", addrs_w.size(), 4);
    for (int k = 0; k < 4; k++) check("t4_addr", addrs_w[k], exp_wrap[k]);
    check("t4_noread", bus_w.flash_mem_read, 0);
    rdy_w = 1'b1;
    repeat (12) @(negedge clk);
    check("t4_drained", got_w.size(), 8);
    check("t4_first",   got_w[0], 16'h0003);
    check("t4_last",    got_w[7], 16'hC003);
    check("t4_empty",   bus_w.sample_valid, 0);
    check("t4_done_hold", done_w, 1);
`else
    rdy_w = 1'b1; en_w = 1'b1;
    for (int i = 0; i < 400 && addrs_w.size() < 6; i++) @(negedge clk);
    $display("t4: reads=%0d", addrs_w.size());
    for (int k = 0; k < 6; k++) check("t4_wrap_addr", addrs_w[k], exp_wrap[k]);
    check("t4_nodone", done_w, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
